// File: rtl/lut_perm_pkg.sv
// Shared definitions for the LUT input-permutation enumerator family.
// Contents:
//   state_t        enumerator FSM states (IDLE, EMIT, FIN)
//   clog2_min1     ceil(log2(v)), never less than 1
//   factorial      n! for small n (N <= 8)
//   perm_w         bits per permutation element for an n-input LUT
//   identity_perm  packed identity permutation (slot i = i), MAX_N*MAX_W bits
package lut_perm_pkg;

  localparam int unsigned MAX_N = 8;
  localparam int unsigned MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FIN
  } state_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned factorial(input int unsigned n);
    int unsigned f;
    f = 1;
    for (int unsigned i = 2; i <= n; i++) begin
      f = f * i;
    end
    return f;
  endfunction

  function automatic int unsigned perm_w(input int unsigned n);
    return clog2_min1(n);
  endfunction

  function automatic logic [MAX_N*MAX_W-1:0] identity_perm(input int unsigned n,
                                                          input int unsigned w);
    logic [MAX_N*MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned b = 0; b < w; b++) begin
        r[i*w+b] = i[b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lut_perm_next.sv
// Combinational lexicographic successor of an N-element permutation.
// Ports:
//   cur_i  N*W  current permutation, slot i = cur_i[i*W +: W], slot 0 most significant
//   nxt_o  N*W  next permutation in lexicographic order (cur_i when cur_i is the last one)
module lut_perm_next
  import lut_perm_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = perm_w(N)
) (
  input  logic [N*W-1:0] cur_i,
  output logic [N*W-1:0] nxt_o
);

  // Every array index below is a loop constant compared against k/l, so the
  // selects stay static and the logic unrolls into plain muxes.
  always_comb begin
    logic [W-1:0] s [N];
    logic [W-1:0] t [N];
    logic [W-1:0] r [N];
    logic         found;
    int unsigned  k;
    int unsigned  l;
    logic [W-1:0] sk;
    logic [W-1:0] sl;

    found = 1'b0;
    k     = 0;
    l     = 0;
    sk    = '0;
    sl    = '0;
    nxt_o = '0;

    for (int unsigned i = 0; i < N; i++) begin
      s[i] = cur_i[i*W +: W];
    end

    // largest k with s[k] < s[k+1]
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (s[i] < s[i+1]) begin
        found = 1'b1;
        k     = i;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (i == k) sk = s[i];
    end

    // largest l > k with s[l] > s[k]
    for (int unsigned j = 0; j < N; j++) begin
      if (j > k && s[j] > sk) l = j;
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (j == l) sl = s[j];
    end

    for (int unsigned j = 0; j < N; j++) begin
      t[j] = (j == k) ? sl : (j == l) ? sk : s[j];
    end

    // reverse the tail k+1..N-1: slot j takes slot N+k-j
    for (int unsigned j = 0; j < N; j++) begin
      r[j] = t[j];
      if (j > k) begin
        for (int unsigned m = 0; m < N; m++) begin
          if (m == N + k - j) r[j] = t[m];
        end
      end
    end

    for (int unsigned j = 0; j < N; j++) begin
      nxt_o[j*W +: W] = found ? r[j] : s[j];
    end
  end

endmodule

// File: rtl/lut_perm_enumerator.sv
// Streams all N! permutations of an N-input LUT's input ordering in
// lexicographic order, one per valid/ready handshake.
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  begins an enumeration when idle (ignored while busy or in FIN)
//   busy   high from accepted start until the last permutation is accepted
//   prm    current permutation, slot i = prm[i*W +: W]
//   idx    ordinal of prm, 0 .. N!-1
//   last   high while idx == N!-1
//   valid  prm/idx/last valid
//   ready  downstream accept
//   done   one-cycle pulse after the last permutation is accepted
module lut_perm_enumerator
  import lut_perm_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = perm_w(N),
  parameter int unsigned IW = clog2_min1(factorial(N))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic [N*W-1:0] prm,
  output logic [IW-1:0] idx,
  output logic          last,
  output logic          valid,
  input  logic          ready,
  output logic          done
);

  localparam int unsigned     NFACT    = factorial(N);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NFACT - 1);
  localparam logic [N*W-1:0]  IDENT    = (N*W)'(identity_perm(N, W));

  state_t          state_q;
  logic [N*W-1:0]  prm_q;
  logic [N*W-1:0]  prm_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic            last_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;

  lut_perm_next #(
    .N (N),
    .W (W)
  ) u_next (
    .cur_i (prm_q),
    .nxt_o (prm_d)
  );

  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prm_q   <= IDENT;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            prm_q   <= IDENT;
            idx_q   <= '0;
            last_q  <= (NFACT == 1);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              prm_q  <= prm_d;
              idx_q  <= idx_d;
              last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign prm   = prm_q;
  assign idx   = idx_q;
  assign last  = last_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_lut_perm_enumerator.sv
module tb_lut_perm_enumerator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=3 instance
  logic       rst3, start3, ready3;
  logic       busy3, last3, valid3, done3;
  logic [5:0] prm3;
  logic [2:0] idx3;

  // N=4 instance
  logic       rst4, start4, ready4;
  logic       busy4, last4, valid4, done4;
  logic [7:0] prm4;
  logic [4:0] idx4;

  // N=1 instance
  logic       rst1, start1, ready1;
  logic       busy1, last1, valid1, done1;
  logic [0:0] prm1;
  logic [0:0] idx1;

  lut_perm_enumerator #(.N(3)) u3 (
    .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .prm(prm3),
    .idx(idx3), .last(last3), .valid(valid3), .ready(ready3), .done(done3)
  );

  lut_perm_enumerator #(.N(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .prm(prm4),
    .idx(idx4), .last(last4), .valid(valid4), .ready(ready4), .done(done4)
  );

  lut_perm_enumerator #(.N(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .prm(prm1),
    .idx(idx1), .last(last1), .valid(valid1), .ready(ready1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rank -> permutation for N=4 via the factorial number system.
  function automatic logic [7:0] unrank4(input int unsigned r);
    int unsigned avail [4];
    int unsigned ftab  [4];
    int unsigned rem, d, v;
    logic [7:0]  p;
    ftab = '{6, 2, 1, 1};
    for (int unsigned i = 0; i < 4; i++) avail[i] = i;
    rem = r;
    p   = '0;
    for (int unsigned pos = 0; pos < 4; pos++) begin
      d   = rem / ftab[pos];
      rem = rem % ftab[pos];
      v   = avail[d];
      p[pos*2 +: 2] = v[1:0];
      for (int unsigned q = d; q + 1 < 4; q++) avail[q] = avail[q+1];
    end
    return p;
  endfunction

  typedef struct {
    logic       start;
    logic       ready;
    logic       valid;
    logic [2:0] idx;
    logic [5:0] prm;
    logic       last;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [8];

  int          cnt, hs, dn, cyc;
  logic        stalled, seen_done;
  logic [7:0]  held_prm;
  logic [4:0]  held_idx;

  initial begin
    // expected outputs one edge after the inputs of the same row
    tbl[0] = '{1'b1, 1'b1, 1'b1, 3'd0, 6'h24, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 3'd1, 6'h18, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 3'd2, 6'h21, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 3'd3, 6'h09, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 3'd4, 6'h12, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 3'd5, 6'h06, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 3'd5, 6'h06, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 3'd5, 6'h06, 1'b1, 1'b0, 1'b0};

    rst3 = 1'b1; start3 = 1'b0; ready3 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; ready4 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; ready1 = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst3_valid", valid3, 0);
    chk("rst3_busy",  busy3,  0);
    chk("rst3_last",  last3,  0);
    chk("rst3_done",  done3,  0);
    chk("rst3_idx",   idx3,   0);
    chk("rst3_prm",   prm3,   6'h24);
    chk("rst4_prm",   prm4,   8'hE4);
    chk("rst4_valid", valid4, 0);
    chk("rst1_prm",   prm1,   0);
    chk("rst1_valid", valid1, 0);

    rst3 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
    tick();

    // N=3 full enumeration, ready held high
    for (int i = 0; i < 8; i++) begin
      start3 = tbl[i].start;
      ready3 = tbl[i].ready;
      tick();
      chk($sformatf("n3_valid[%0d]", i), valid3, tbl[i].valid);
      chk($sformatf("n3_idx[%0d]", i),   idx3,   tbl[i].idx);
      chk($sformatf("n3_prm[%0d]", i),   prm3,   tbl[i].prm);
      chk($sformatf("n3_last[%0d]", i),  last3,  tbl[i].last);
      chk($sformatf("n3_busy[%0d]", i),  busy3,  tbl[i].busy);
      chk($sformatf("n3_done[%0d]", i),  done3,  tbl[i].done);
    end
    start3 = 1'b0;

    // N=3 reset on the third handshake cycle
    start3 = 1'b1; ready3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();              // idx0 accepted
    tick();              // idx1 accepted, now showing idx2
    chk("n3rst_idx_before", idx3, 2);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk("n3rst_busy",  busy3,  0);
    chk("n3rst_valid", valid3, 0);
    chk("n3rst_idx",   idx3,   0);
    chk("n3rst_prm",   prm3,   6'h24);
    chk("n3rst_done",  done3,  0);
    tick();
    chk("n3rst_done2", done3,  0);
    chk("n3rst_valid2", valid3, 0);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("n3restart_valid", valid3, 1);
    chk("n3restart_idx",   idx3,   0);
    chk("n3restart_prm",   prm3,   6'h24);
    cyc = 0;
    while (!done3 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("n3restart_done_seen", done3, 1);
    ready3 = 1'b0;
    tick();

    // start and rst together: rst wins
    rst3 = 1'b1; start3 = 1'b1;
    tick();
    rst3 = 1'b0; start3 = 1'b0;
    chk("rststart_valid", valid3, 0);
    chk("rststart_busy",  busy3,  0);
    chk("rststart_idx",   idx3,   0);
    chk("rststart_prm",   prm3,   6'h24);
    tick();
    chk("rststart_valid2", valid3, 0);

    // N=4 with random backpressure
    start4 = 1'b1; ready4 = 1'b0;
    tick();
    start4 = 1'b0;
    cnt = 0; cyc = 0; stalled = 1'b0; held_prm = '0; held_idx = '0;
    while (cnt < 24 && cyc < 600) begin
      ready4 = 1'($urandom_range(0, 1));
      chk("n4_valid", valid4, 1);
      chk("n4_idx",   idx4,   cnt);
      chk("n4_prm",   prm4,   unrank4(cnt));
      chk("n4_last",  last4,  (cnt == 23) ? 1 : 0);
      if (stalled) begin
        chk("n4_hold_prm", prm4, held_prm);
        chk("n4_hold_idx", idx4, held_idx);
      end
      stalled  = valid4 && !ready4;
      held_prm = prm4;
      held_idx = idx4;
      if (valid4 && ready4) cnt++;
      tick();
      cyc++;
    end
    chk("n4_handshakes_in_budget", cnt, 24);
    chk("n4_done",  done4,  1);
    chk("n4_busy",  busy4,  0);
    chk("n4_valid_end", valid4, 0);
    chk("n4_final_prm", prm4, 8'h1B);
    chk("n4_final_idx", idx4, 23);
    ready4 = 1'b0;
    tick();
    chk("n4_done_pulse", done4, 0);

    // N=4 start held while busy and during FIN
    hs = 0; dn = 0; seen_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      start4 = !seen_done || done4;
      ready4 = 1'b1;
      if (valid4) hs++;
      if (done4) begin
        dn++;
        seen_done = 1'b1;
      end
      tick();
    end
    start4 = 1'b0;
    chk("n4start_handshakes", hs, 24);
    chk("n4start_dones", dn, 1);
    chk("n4start_busy", busy4, 0);
    chk("n4start_valid", valid4, 0);

    // N=1 single beat
    start1 = 1'b1; ready1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1_valid", valid1, 1);
    chk("n1_prm",   prm1,   0);
    chk("n1_idx",   idx1,   0);
    chk("n1_last",  last1,  1);
    chk("n1_busy",  busy1,  1);
    tick();
    chk("n1_done",  done1,  1);
    chk("n1_valid_off", valid1, 0);
    chk("n1_busy_off",  busy1,  0);
    tick();
    chk("n1_done_off", done1, 0);
    chk("n1_idle_valid", valid1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
